mux_share_arbiter: RTL and testbench
====================================

Name: mux_share_arbiter

Overview:
- Round-robin arbiter that shares the 32-bit 2:1 datapath multiplexer between two streaming requesters.
- Owns the multiplexer select and holds it stable for the whole burst of the granted requester.
- Forwards accepted beats through a single registered output stage with valid/ready handshake.
- Sits between two producers (e.g. ALU result path and load-return path) and one shared 32-bit consumer.

Parameters:
- DATA_W, 32, width of data beats and of the multiplexer inputs.
- MAX_BEATS, 16, maximum accepted beats per grant before forced release; 0 disables the limit.
- CNT_W, 5, width of the beat counter; must hold MAX_BEATS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a beat.
- req0_data  input  DATA_W  requester 0 beat data.
- req0_last  input  1  final beat of requester 0 burst.
- req0_ready  output  1  requester 0 beat accepted this cycle when high with req0_valid.
- req1_valid  input  1  requester 1 has a beat.
- req1_data  input  DATA_W  requester 1 beat data.
- req1_last  input  1  final beat of requester 1 burst.
- req1_ready  output  1  requester 1 beat accepted when high with req1_valid.
- sel  output  1  multiplexer select; 0 = requester 0, 1 = requester 1; registered.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered beat.
- out_last  output  1  registered last flag; also high on a forced-release beat.
- out_ready  input  1  consumer accepts the beat.
- busy  output  1  a grant is active (state OWN).

Behaviour:
- Reset (async, rst_n low): state IDLE, sel=0, prio=0 (requester 0 first), beat_cnt=0, out_valid=0, out_data=0, out_last=0, busy=0, both ready=0.
- Reset asserted mid-burst clears everything immediately; the in-flight beat is lost.
- States: IDLE, OWN.
- IDLE:
  - both ready=0.
  - If only reqN_valid is high, the next edge sets sel=N, state=OWN, busy=1.
  - If both are high, sel=prio.
  - If neither is high, stay in IDLE; sel holds its last value.
  - Arbitration costs exactly one cycle; the first beat can be accepted no earlier than the cycle after the grant.
- OWN:
  - can_load = !out_valid | out_ready.
  - Ready of the owner = can_load; the non-owner's ready = 0.
  - Accept = owner valid & owner ready: out_data <= mux output (selected by sel), out_valid <= 1, beat_cnt++.
  - out_valid clears when out_ready is high and no accept occurs that cycle.
  - Simultaneous drain and load gives full throughput: one beat per cycle.
- Release: taken on the edge of an accept where owner last=1, or where beat_cnt==MAX_BEATS-1 (MAX_BEATS≠0).
  - Actions: state=IDLE, busy=0, beat_cnt=0, prio=~sel.
  - out_last <= owner last | forced release.
- Owner dropping valid mid-burst: the grant is held indefinitely. No timeout on idle cycles; only accepted beats are counted.
- The non-owner's valid is ignored during OWN. Data from a non-owner is never forwarded.
- sel changes only on the IDLE→OWN edge. It never toggles while out_valid holds a beat from the current owner.
- The output beat stays stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset, then req0_valid=1, data=0xA5A5_0001, last=1, out_ready=1 -> sel=0 after 1 cycle, req0_ready high the next cycle; out_data=0xA5A5_0001, out_last=1 one cycle after accept; back to IDLE, prio=1.
- Both valid from reset, each sending 3-beat bursts -> requester 0 served first (beats 0x10, 0x11, 0x12), then requester 1 (0x20, 0x21, 0x22); one idle arbitration cycle between bursts; no interleaving.
- MAX_BEATS=4, requester 1 streams 10 beats with last=0 while requester 0 also waits -> release after 4 beats with out_last=1 on beat 4; requester 0 granted next; requester 1 resumes later.
- Backpressure: out_ready=0 for 5 cycles during a burst -> out_data is held constant, owner ready=0 after the first load, no beat lost or duplicated; 4-beat checksum matches.
- Owner valid gaps of 3 cycles mid-burst with the other requester valid -> sel stays fixed; no grant switch until last.
- rst_n pulsed low mid-burst with out_valid=1 -> out_valid=0, sel=0, busy=0 immediately; after release, arbitration restarts from prio=0.

Source files
------------

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin owner of a shared 2:1 data mux feeding one registered valid/ready output stage
module mux_share_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t            state_q, state_d;
  logic              sel_q, sel_d, prio_q, prio_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, mux_data;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own, can_load, own_valid, own_last, accept, forced, rel;
  always_comb begin
    own         = state_q == OWN;
    mux_data    = sel_q ? req1_data : req0_data;
    own_valid   = sel_q ? req1_valid : req0_valid;
    own_last    = sel_q ? req1_last : req0_last;
    can_load    = !out_valid_q || out_ready;
    accept      = own && own_valid && can_load;
    forced      = (MAX_BEATS != 0) && (cnt_q == CNT_W'(MAX_BEATS - 1));
    rel         = accept && (own_last || forced);
    req0_ready  = own && !sel_q && can_load;
    req1_ready  = own && sel_q && can_load;
    // both valid in IDLE falls back to the round-robin pointer
    sel_d       = (!own && (req0_valid || req1_valid)) ? ((req0_valid && req1_valid) ? prio_q : req1_valid) : sel_q;
    state_d     = rel ? IDLE : ((!own && (req0_valid || req1_valid)) ? OWN : state_q);
    prio_d      = rel ? ~sel_q : prio_q;
    cnt_d       = rel ? '0 : (accept ? cnt_q + 1'b1 : cnt_q);
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_data_d  = accept ? mux_data : out_data_q;
    out_last_d  = accept ? (own_last || forced) : out_last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = own;
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed bench with queue-driven producers and a hand-written expected beat order
module tb_mux_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_last, req0_ready;
  logic        req1_valid, req1_last, req1_ready;
  logic [31:0] req0_data, req1_data, out_data;
  logic        sel, out_valid, out_last, out_ready, busy;
  int          total = 0, bad = 0;
  logic [31:0] q0[$], q1[$], rx_d[$];
  logic        l0[$], l1[$], rx_l[$];
  logic        en0 = 1'b0, en1 = 1'b0;
  logic [31:0] sum;
  logic [31:0] e2[6]  = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h21, 32'h22};
  logic [31:0] e3[12] = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h40, 32'h41,
                          32'h34, 32'h35, 32'h36, 32'h37, 32'h38, 32'h39};
  logic        e3l[12] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0};
  logic [31:0] e5[5]  = '{32'h50, 32'h51, 32'h52, 32'h60, 32'h61};

  mux_share_arbiter #(.DATA_W(32), .MAX_BEATS(4), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive();
    req0_valid = en0 && q0.size() > 0;
    req0_data  = q0.size() > 0 ? q0[0] : 32'h0;
    req0_last  = l0.size() > 0 ? l0[0] : 1'b0;
    req1_valid = en1 && q1.size() > 0;
    req1_data  = q1.size() > 0 ? q1[0] : 32'h0;
    req1_last  = l1.size() > 0 ? l1[0] : 1'b0;
  endtask

  task automatic fill(input int who, input logic [31:0] base, input int n, input logic last_end);
    for (int i = 0; i < n; i++) begin
      if (who == 0) begin q0.push_back(base + 32'(i)); l0.push_back(last_end && i == n - 1); end
      else          begin q1.push_back(base + 32'(i)); l1.push_back(last_end && i == n - 1); end
    end
  endtask

  task automatic step();
    logic a0, a1;
    #1;
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    if (out_valid && out_ready) begin rx_d.push_back(out_data); rx_l.push_back(out_last); end
    @(posedge clk); #1;
    if (a0) begin void'(q0.pop_front()); void'(l0.pop_front()); end
    if (a1) begin void'(q1.pop_front()); void'(l1.pop_front()); end
    drive();
    #1;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && rx_d.size() < n; k++) step();
    chk(tag, 32'(rx_d.size()), 32'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete(); l0.delete(); q1.delete(); l1.delete();
    rx_d.delete(); rx_l.delete();
    en0 = 1'b0; en1 = 1'b0; out_ready = 1'b1;
    drive();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    out_ready = 1'b1;
    drive();
    @(posedge clk); #1;
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_ol", out_last, 0);
    chk("rst_rdy", {req0_ready, req1_ready}, 0);
    rst_n = 1'b1;

    fill(0, 32'hA5A5_0001, 1, 1'b1); en0 = 1'b1; drive(); #1;
    chk("s1_idle_rdy", req0_ready, 0);
    step();
    chk("s1_sel", sel, 0);
    chk("s1_busy", busy, 1);
    chk("s1_rdy", req0_ready, 1);
    chk("s1_ov_pre", out_valid, 0);
    step();
    chk("s1_ov", out_valid, 1);
    chk("s1_od", out_data, 32'hA5A5_0001);
    chk("s1_ol", out_last, 1);
    chk("s1_rel", busy, 0);
    fill(0, 32'hB0, 1, 1'b1); fill(1, 32'hB1, 1, 1'b1); en1 = 1'b1; drive();
    step();
    chk("s1_prio", sel, 1);

    do_reset();
    fill(0, 32'h10, 3, 1'b1); fill(1, 32'h20, 3, 1'b1); en0 = 1'b1; en1 = 1'b1; drive();
    run_until(6, 40, "s2_cnt");
    for (int i = 0; i < 6; i++) chk($sformatf("s2_d%0d", i), rx_d[i], e2[i]);

    do_reset();
    fill(1, 32'h30, 10, 1'b0); en1 = 1'b1; drive();
    step();
    chk("s3_sel1", sel, 1);
    fill(0, 32'h40, 2, 1'b1); en0 = 1'b1; drive();
    run_until(12, 80, "s3_cnt");
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("s3_d%0d", i), rx_d[i], e3[i]);
      chk($sformatf("s3_l%0d", i), rx_l[i], e3l[i]);
    end

    do_reset();
    fill(0, 32'h100, 4, 1'b1); en0 = 1'b1; drive();
    step(); step();
    chk("s4_ov", out_valid, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("s4_hold%0d", i), out_data, 32'h100);
      chk($sformatf("s4_rdy%0d", i), req0_ready, 0);
    end
    out_ready = 1'b1;
    run_until(4, 30, "s4_cnt");
    sum = 32'h0;
    foreach (rx_d[i]) sum += rx_d[i];
    chk("s4_sum", sum, 32'h406);
    chk("s4_last", rx_l[3], 1);

    do_reset();
    fill(0, 32'h50, 3, 1'b1); fill(1, 32'h60, 2, 1'b1); en0 = 1'b1; en1 = 1'b1; drive();
    step(); step();
    en0 = 1'b0; drive();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("s5_sel%0d", i), sel, 0);
      chk($sformatf("s5_busy%0d", i), busy, 1);
      chk($sformatf("s5_r1_%0d", i), req1_ready, 0);
    end
    en0 = 1'b1; drive();
    run_until(5, 40, "s5_cnt");
    for (int i = 0; i < 5; i++) chk($sformatf("s5_d%0d", i), rx_d[i], e5[i]);

    do_reset();
    fill(0, 32'h7F, 1, 1'b1); en0 = 1'b1; drive();
    step(); step();
    fill(1, 32'h70, 3, 1'b1); en1 = 1'b1; drive();
    step();
    out_ready = 1'b0;
    step();
    chk("s6_pre_sel", sel, 1);
    chk("s6_pre_ov", out_valid, 1);
    rst_n = 1'b0; #1;
    chk("s6_ov", out_valid, 0);
    chk("s6_sel", sel, 0);
    chk("s6_busy", busy, 0);
    chk("s6_od", out_data, 0);
    do_reset();
    fill(0, 32'h80, 1, 1'b1); fill(1, 32'h90, 1, 1'b1); en0 = 1'b1; en1 = 1'b1; drive();
    step();
    chk("s6_prio0", sel, 0);
    run_until(2, 20, "s6_cnt");
    chk("s6_d0", rx_d[0], 32'h80);
    chk("s6_d1", rx_d[1], 32'h90);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
